card_select_ctrl: RTL



---
 rtl/card_select_ctrl_if.sv | 29 ++
 rtl/card_select_ctrl.sv | 159 +++++++++++++++
 2 files changed

// File: rtl/card_select_ctrl_if.sv
// Player-side bus of the card selection controller: button pulses and the
// eliminated mask in, cursor / pick / compare-strobe / display state out.
interface card_select_ctrl_if;
  logic        north;
  logic        south;
  logic        east;
  logic        west;
  logic        center;
  logic [15:0] eliminated;
  logic [3:0]  cursor;
  logic [4:0]  choose_1;
  logic [4:0]  choose_2;
  logic        C2;
  logic [15:0] face_up;
  logic [7:0]  moves;
  logic        done;

  // Player / environment side
  modport master (
    output north, south, east, west, center, eliminated,
    input  cursor, choose_1, choose_2, C2, face_up, moves, done
  );

  // Controller side
  modport slave (
    input  north, south, east, west, center, eliminated,
    output cursor, choose_1, choose_2, C2, face_up, moves, done
  );
endinterface

// File: rtl/card_select_ctrl.sv
// Card selection controller for the 4x4 matching game: moves a wrapping cursor,
// captures two picks, strobes C2 for the eliminator, then shows both cards for
// SHOW_CYCLES before flipping them back.
// Optional feature: define CARD_SELECT_TIMEOUT_EN to abandon an unfinished pair
// after TIMEOUT_CYCLES idle cycles in the second-pick phase.
module card_select_ctrl #(
  parameter int unsigned SHOW_CYCLES    = 2000,
  parameter int unsigned TIMEOUT_CYCLES = 8000
) (
  input logic               new_clk,
  input logic               rst,
  card_select_ctrl_if.slave bus
);

  localparam int unsigned ShowW = $clog2(SHOW_CYCLES + 1);
  localparam logic [ShowW-1:0] ShowLast = ShowW'(SHOW_CYCLES - 1);
  localparam logic [4:0] NoPick = 5'd31;

  typedef enum logic [1:0] {StPick1, StPick2, StShow, StDone} state_e;

  state_e           state_q, state_d;
  logic [3:0]       cursor_q, cursor_d;
  logic [4:0]       choose1_q, choose1_d;
  logic [4:0]       choose2_q, choose2_d;
  logic             c2_q, c2_d;
  logic [15:0]      face_up_q, face_up_d;
  logic [7:0]       moves_q, moves_d;
  logic [ShowW-1:0] show_cnt_q, show_cnt_d;

  logic [1:0] row, col;
  logic       dir_any;
  logic       pick_ok;

  assign row     = cursor_q[3:2];
  assign col     = cursor_q[1:0];
  assign dir_any = bus.north | bus.south | bus.east | bus.west;
  assign pick_ok = bus.center & ~bus.eliminated[cursor_q];

`ifdef CARD_SELECT_TIMEOUT_EN
  localparam int unsigned IdleW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [IdleW-1:0] IdleLast = IdleW'(TIMEOUT_CYCLES - 1);
  logic [IdleW-1:0] idle_q, idle_d;
  logic             btn_any;
  assign btn_any = dir_any | bus.center;
`else
  logic unused_timeout_cfg;
  assign unused_timeout_cfg = ^TIMEOUT_CYCLES;
`endif

  // State register and datapath registers, synchronous reset
  always_ff @(posedge new_clk) begin
    if (rst) begin
      state_q    <= StPick1;
      cursor_q   <= '0;
      choose1_q  <= NoPick;
      choose2_q  <= NoPick;
      c2_q       <= 1'b0;
      face_up_q  <= '0;
      moves_q    <= '0;
      show_cnt_q <= '0;
`ifdef CARD_SELECT_TIMEOUT_EN
      idle_q     <= '0;
`endif
    end else begin
      state_q    <= state_d;
      cursor_q   <= cursor_d;
      choose1_q  <= choose1_d;
      choose2_q  <= choose2_d;
      c2_q       <= c2_d;
      face_up_q  <= face_up_d;
      moves_q    <= moves_d;
      show_cnt_q <= show_cnt_d;
`ifdef CARD_SELECT_TIMEOUT_EN
      idle_q     <= idle_d;
`endif
    end
  end

  // Next-state: cursor movement, pick capture, show window and DONE decision
  always_comb begin
    state_d    = state_q;
    cursor_d   = cursor_q;
    choose1_d  = choose1_q;
    choose2_d  = choose2_q;
    c2_d       = 1'b0;
    face_up_d  = face_up_q;
    moves_d    = moves_q;
    show_cnt_d = show_cnt_q;
`ifdef CARD_SELECT_TIMEOUT_EN
    idle_d     = idle_q;
`endif

    // A select freezes the cursor so the pick uses the pre-move position
    if (state_q != StDone && !bus.center && dir_any) begin
      if (bus.north)      cursor_d = {row - 2'd1, col};
      else if (bus.south) cursor_d = {row + 2'd1, col};
      else if (bus.east)  cursor_d = {row, col + 2'd1};
      else                cursor_d = {row, col - 2'd1};
    end

    unique case (state_q)
      StPick1: begin
        if (pick_ok) begin
          choose1_d           = {1'b0, cursor_q};
          face_up_d[cursor_q] = 1'b1;
          state_d             = StPick2;
`ifdef CARD_SELECT_TIMEOUT_EN
          idle_d              = '0;
`endif
        end
      end
      StPick2: begin
        if (pick_ok && ({1'b0, cursor_q} != choose1_q)) begin
          choose2_d           = {1'b0, cursor_q};
          face_up_d[cursor_q] = 1'b1;
          c2_d                = 1'b1;
          moves_d             = (moves_q == 8'hFF) ? moves_q : moves_q + 8'd1;
          show_cnt_d          = '0;
          state_d             = StShow;
        end
`ifdef CARD_SELECT_TIMEOUT_EN
        else if (btn_any) begin
          idle_d = '0;
        end else if (idle_q == IdleLast) begin
          choose1_d = NoPick;
          face_up_d = '0;
          state_d   = StPick1;
        end else begin
          idle_d = idle_q + IdleW'(1);
        end
`endif
      end
      StShow: begin
        if (show_cnt_q == ShowLast) begin
          choose1_d = NoPick;
          choose2_d = NoPick;
          face_up_d = '0;
          state_d   = (bus.eliminated == 16'hFFFF) ? StDone : StPick1;
        end else begin
          show_cnt_d = show_cnt_q + ShowW'(1);
        end
      end
      StDone: begin
      end
    endcase
  end

  // Outputs come straight from registers; done is decoded from state
  always_comb begin
    bus.cursor   = cursor_q;
    bus.choose_1 = choose1_q;
    bus.choose_2 = choose2_q;
    bus.C2       = c2_q;
    bus.face_up  = face_up_q;
    bus.moves    = moves_q;
    bus.done     = (state_q == StDone);
  end

endmodule
